// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC0808-style responder.
package adc_pkg;

  localparam int unsigned ADC_DATA_W = 8;
  localparam int unsigned ADC_NUM_CH = 8;
  localparam int unsigned ADC_ADDR_W = $clog2(ADC_NUM_CH);
  localparam int unsigned ADC_BUS_W  = ADC_DATA_W * ADC_NUM_CH;

  // Converter handshake states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_DELAY   = 2'd2,
    ST_CONVERT = 2'd3
  } adc_state_e;

  // EOC idles high between conversions
  localparam logic ADC_EOC_RESET = 1'b1;

  // Pick channel `sel` out of the packed channel bus
  function automatic logic [ADC_DATA_W-1:0] adc_ch_select(
    input logic [ADC_BUS_W-1:0]  ch,
    input logic [ADC_ADDR_W-1:0] sel
  );
    logic [ADC_DATA_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < ADC_NUM_CH; i++) begin
      if (sel == ADC_ADDR_W'(i)) v = ch[i*ADC_DATA_W +: ADC_DATA_W];
    end
    return v;
  endfunction

endpackage

// File: rtl/adc_responder_if.sv
// Controller <-> converter handshake pins (START/ALE/OE/ADD in, EOC/data out).
interface adc_responder_if;
  import adc_pkg::*;

  logic                  start;
  logic                  ale;
  logic                  oe;
  logic                  add_a;
  logic                  add_b;
  logic                  add_c;
  logic                  eoc;
  logic [ADC_DATA_W-1:0] data_out;
  logic                  data_oe;

  // FPGA-side ADC controller
  modport master (
    output start, ale, oe, add_a, add_b, add_c,
    input  eoc, data_out, data_oe
  );

  // Converter model side
  modport slave (
    input  start, ale, oe, add_a, add_b, add_c,
    output eoc, data_out, data_oe
  );

endinterface

// File: rtl/adc_sar_core.sv
// Conversion tick counter and result register.
// Optional macro SAR_PROGRESS_EN: resolve the result MSB first, one bit every
// CONV_CYCLES/8 ticks, instead of updating it atomically at the end.
module adc_sar_core
  import adc_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear_i,
  input  logic                  active_i,
  input  logic                  conv_tick_i,
  input  logic [ADC_DATA_W-1:0] sample_i,
  output logic [ADC_DATA_W-1:0] result_o,
  output logic                  done_c_o
);

  localparam int unsigned CNT_W = $clog2(CONV_CYCLES + 1);

  logic [CNT_W-1:0]      cnt_q;
  logic [ADC_DATA_W-1:0] result_q;

`ifdef SAR_PROGRESS_EN
  localparam int unsigned SAR_STEP = CONV_CYCLES / ADC_DATA_W;
  localparam int unsigned STEP_W   = (SAR_STEP > 1) ? $clog2(SAR_STEP) : 1;
  localparam int unsigned BIT_W    = $clog2(ADC_DATA_W);

  logic [STEP_W-1:0] sub_q;
  logic [BIT_W-1:0]  bit_q;
`endif

  // Final tick of the conversion
  assign done_c_o = active_i && conv_tick_i && (cnt_q == CNT_W'(CONV_CYCLES - 1));
  assign result_o = result_q;

  // Tick counting and result update
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      result_q <= '0;
`ifdef SAR_PROGRESS_EN
      sub_q    <= '0;
      bit_q    <= BIT_W'(ADC_DATA_W - 1);
`endif
    end else if (clear_i) begin
      cnt_q    <= '0;
`ifdef SAR_PROGRESS_EN
      result_q <= '0;
      sub_q    <= '0;
      bit_q    <= BIT_W'(ADC_DATA_W - 1);
`endif
    end else if (active_i && conv_tick_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
`ifdef SAR_PROGRESS_EN
      if (sub_q == STEP_W'(SAR_STEP - 1)) begin
        sub_q           <= '0;
        result_q[bit_q] <= sample_i[bit_q];
        bit_q           <= bit_q - BIT_W'(1);
      end else begin
        sub_q <= sub_q + STEP_W'(1);
      end
`else
      if (done_c_o) result_q <= sample_i;
`endif
    end
  end

endmodule

// File: rtl/adc_responder.sv
// Converter-side model of the ADC0808 handshake for loopback/bring-up builds.
// Optional macro SAR_PROGRESS_EN: progressive (bit-serial) result visibility.
module adc_responder
  import adc_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = 64,
  parameter int unsigned EOC_DELAY   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  adc_responder_if.slave        bus,
  input  logic                  conv_tick,
  input  logic [ADC_BUS_W-1:0]  ch_in,
  output logic [ADC_ADDR_W-1:0] addr_latched
);

  localparam int unsigned DLY_W = (EOC_DELAY > 1) ? $clog2(EOC_DELAY) : 1;

  adc_state_e            state_q;
  logic                  start_q;
  logic                  ale_q;
  logic [ADC_ADDR_W-1:0] addr_q;
  logic [DLY_W-1:0]      dly_q;
  logic [ADC_DATA_W-1:0] sample_q;
  logic                  eoc_q;
  logic [ADC_DATA_W-1:0] data_out_q;
  logic                  data_oe_q;

  logic                  start_rise_c;
  logic                  start_fall_c;
  logic                  ale_rise_c;
  logic [ADC_ADDR_W-1:0] addr_pins_c;
  logic [ADC_ADDR_W-1:0] addr_sel_c;
  logic                  clear_c;
  logic                  active_c;
  logic                  done_c;
  logic [ADC_DATA_W-1:0] result_c;

  assign start_rise_c = bus.start & ~start_q;
  assign start_fall_c = ~bus.start & start_q;
  assign ale_rise_c   = bus.ale & ~ale_q;
  assign addr_pins_c  = {bus.add_c, bus.add_b, bus.add_a};

  // A same-cycle ALE rise overrides the held address for the sample
  assign addr_sel_c = ale_rise_c ? addr_pins_c : addr_q;

  // A restart wins over entering/continuing CONVERT
  assign clear_c  = (state_q == ST_DELAY) && (dly_q == '0) && !start_rise_c;
  assign active_c = (state_q == ST_CONVERT) && !start_rise_c;

  adc_sar_core #(
    .CONV_CYCLES (CONV_CYCLES)
  ) u_sar_core (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (clear_c),
    .active_i    (active_c),
    .conv_tick_i (conv_tick),
    .sample_i    (sample_q),
    .result_o    (result_c),
    .done_c_o    (done_c)
  );

  // Edge history, address latch, handshake FSM and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      ale_q      <= 1'b0;
      addr_q     <= '0;
      dly_q      <= '0;
      sample_q   <= '0;
      eoc_q      <= ADC_EOC_RESET;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
    end else begin
      start_q    <= bus.start;
      ale_q      <= bus.ale;
      data_oe_q  <= bus.oe;
      data_out_q <= bus.oe ? result_c : '0;

      if (ale_rise_c) addr_q <= addr_pins_c;

      case (state_q)
        ST_IDLE: begin
          if (start_rise_c) state_q <= ST_ARMED;
        end
        ST_ARMED: begin
          if (start_fall_c) begin
            sample_q <= adc_ch_select(ch_in, addr_sel_c);
            dly_q    <= DLY_W'(EOC_DELAY - 1);
            state_q  <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (start_rise_c) begin
            state_q <= ST_ARMED;
          end else if (dly_q == '0) begin
            eoc_q   <= 1'b0;
            state_q <= ST_CONVERT;
          end else begin
            dly_q <= dly_q - DLY_W'(1);
          end
        end
        ST_CONVERT: begin
          if (start_rise_c) begin
            state_q <= ST_ARMED;
          end else if (done_c) begin
            eoc_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.eoc      = eoc_q;
  assign bus.data_out = data_out_q;
  assign bus.data_oe  = data_oe_q;
  assign addr_latched = addr_q;

endmodule

// File: tb/tb_adc_responder.sv
// Self-checking bench for adc_responder: table-driven conversions plus
// hand-written restart / mid-conversion latch / reset sequences.
module tb_adc_responder;
  import adc_pkg::*;

  localparam int unsigned CONV = 64;
  localparam int unsigned EDLY = 2;

  logic        clk;
  logic        reset_n;
  logic        conv_tick;
  logic [63:0] ch_in;
  logic [2:0]  addr_latched;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_cnt = 0;
  int tick_div = 1;
  int phase    = 0;
  bit tick_en  = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] prev_result;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] value;
    int         div;
  } vec_t;
  vec_t vecs[5];

  adc_responder_if bus();

  adc_responder #(
    .CONV_CYCLES (CONV),
    .EOC_DELAY   (EDLY)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .conv_tick    (conv_tick),
    .ch_in        (ch_in),
    .addr_latched (addr_latched)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Conversion clock enable: one pulse every tick_div clocks, changed on negedge
  initial begin
    conv_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        if (phase >= tick_div - 1) begin
          conv_tick = 1'b1;
          phase     = 0;
        end else begin
          conv_tick = 1'b0;
          phase++;
        end
      end else begin
        conv_tick = 1'b0;
        phase     = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Advance one clock; conv_tick seen now is the value the DUT sampled
  task automatic step();
    @(posedge clk);
    #1;
    if (conv_tick) tick_cnt++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic latch_addr(input logic [2:0] a);
    {bus.add_c, bus.add_b, bus.add_a} = a;
    bus.ale = 1'b1;
    step();
    bus.ale = 1'b0;
    step();
    chk("addr_latched", 32'(addr_latched), 32'(a));
  endtask

  // START pulse, check EOC timing, push the expected result
  task automatic start_and_drop(input logic [7:0] exp, input bit ale_fall, input logic [2:0] a);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    if (ale_fall) begin
      {bus.add_c, bus.add_b, bus.add_a} = a;
      bus.ale = 1'b1;
    end
    step();
    bus.ale = 1'b0;
    for (int k = 0; k < EDLY; k++) begin
      chk("eoc_high_in_delay", 32'(bus.eoc), 32'd1);
      step();
    end
    chk("eoc_fall", 32'(bus.eoc), 32'd0);
    exp_q.push_back(exp);
    tick_cnt = 0;
  endtask

  task automatic wait_ticks(input int n);
    int g;
    g = 0;
    while (tick_cnt < n && g < 4000) begin
      step();
      g++;
    end
    if (tick_cnt < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL tick_wait: got %0d ticks, expected %0d", tick_cnt, n);
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (bus.eoc !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk("eoc_rise", 32'(bus.eoc), 32'd1);
    chk("conv_ticks", 32'(tick_cnt), 32'(CONV));
  endtask

  // Pop the scoreboard and read the result through OE
  task automatic read_result(input string name);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got nothing, expected an entry", name);
      return;
    end
    e = exp_q.pop_front();
    bus.oe = 1'b1;
    step();
    chk({name, "_data"}, 32'(bus.data_out), 32'(e));
    chk({name, "_oe"}, 32'(bus.data_oe), 32'd1);
    bus.oe = 1'b0;
    step();
    chk({name, "_data_off"}, 32'(bus.data_out), 32'd0);
    chk({name, "_oe_off"}, 32'(bus.data_oe), 32'd0);
    prev_result = e;
  endtask

  initial begin
    vecs[0] = '{addr: 3'd5, value: 8'hA7, div: 4};
    vecs[1] = '{addr: 3'd0, value: 8'h00, div: 1};
    vecs[2] = '{addr: 3'd7, value: 8'hFF, div: 2};
    vecs[3] = '{addr: 3'd3, value: 8'h5A, div: 1};
    vecs[4] = '{addr: 3'd6, value: 8'h81, div: 3};

    // Reset held with START and OE asserted
    reset_n   = 1'b0;
    bus.start = 1'b1;
    bus.oe    = 1'b1;
    bus.ale   = 1'b0;
    {bus.add_c, bus.add_b, bus.add_a} = 3'b000;
    ch_in     = '0;
    prev_result = 8'h00;
    repeat (3) step();
    chk("rst_eoc", 32'(bus.eoc), 32'd1);
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    chk("rst_data_oe", 32'(bus.data_oe), 32'd0);
    chk("rst_addr", 32'(addr_latched), 32'd0);
    bus.start = 1'b0;
    bus.oe    = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    tick_en = 1'b1;

    // Table-driven conversions
    foreach (vecs[i]) begin
      tick_div = vecs[i].div;
      for (int c = 0; c < 8; c++) ch_in[c*8 +: 8] = 8'(8'h10 * c + i + 1);
      ch_in[vecs[i].addr*8 +: 8] = vecs[i].value;
      latch_addr(vecs[i].addr);
      start_and_drop(vecs[i].value, 1'b0, 3'd0);
      wait_done(int'(CONV) * vecs[i].div * 2 + 20);
      read_result("vec");
    end

    // Restart after 30 ticks: new sample wins, EOC stays low, full 64 ticks
    tick_div = 2;
    ch_in[7:0] = 8'h11;
    latch_addr(3'd0);
    start_and_drop(8'h11, 1'b0, 3'd0);
    wait_ticks(30);
    tick_en = 1'b0;
    ch_in[7:0] = 8'h22;
    void'(exp_q.pop_back());
    bus.start = 1'b1;
    step();
    chk("restart_eoc_low_armed", 32'(bus.eoc), 32'd0);
    bus.start = 1'b0;
    step();
    for (int k = 0; k <= EDLY; k++) begin
      chk("restart_eoc_low", 32'(bus.eoc), 32'd0);
      step();
    end
    exp_q.push_back(8'h22);
    tick_cnt = 0;
    tick_en  = 1'b1;
    wait_done(int'(CONV) * 4 + 20);
    read_result("restart");

    // ALE during CONVERT leaves the captured sample alone
    ch_in[15:8]  = 8'h5C;
    ch_in[23:16] = 8'h3E;
    ch_in[39:32] = 8'h4D;
    latch_addr(3'd1);
    start_and_drop(8'h5C, 1'b0, 3'd0);
    wait_ticks(10);
    latch_addr(3'd2);
    wait_done(int'(CONV) * 4 + 20);
    read_result("ale_mid");
    start_and_drop(8'h3E, 1'b0, 3'd0);
    wait_done(int'(CONV) * 4 + 20);
    read_result("next_ch2");
    // ALE rising on the START-fall cycle: new address is used
    start_and_drop(8'h4D, 1'b1, 3'd4);
    chk("ale_on_fall_addr", 32'(addr_latched), 32'd4);
    wait_done(int'(CONV) * 4 + 20);
    read_result("ale_on_fall");

    // OE mid-conversion after 16 ticks
    ch_in[31:24] = 8'hC3;
    latch_addr(3'd3);
    start_and_drop(8'hC3, 1'b0, 3'd0);
    wait_ticks(16);
    bus.oe = 1'b1;
    step();
`ifdef SAR_PROGRESS_EN
    chk("mid_read_partial", 32'(bus.data_out), 32'h0C0);
`else
    chk("mid_read_previous", 32'(bus.data_out), 32'(prev_result));
`endif
    bus.oe = 1'b0;
    step();
    wait_done(int'(CONV) * 4 + 20);
    read_result("mid_final");

    // Reset mid-CONVERT loses the result; next conversion is normal
    ch_in[31:24] = 8'h99;
    start_and_drop(8'h99, 1'b0, 3'd0);
    wait_ticks(10);
    reset_n = 1'b0;
    step();
    chk("midrst_eoc", 32'(bus.eoc), 32'd1);
    chk("midrst_data_oe", 32'(bus.data_oe), 32'd0);
    chk("midrst_addr", 32'(addr_latched), 32'd0);
    reset_n = 1'b1;
    void'(exp_q.pop_back());
    exp_q.push_back(8'h00);
    read_result("after_reset");
    latch_addr(3'd3);
    start_and_drop(8'h99, 1'b0, 3'd0);
    wait_done(int'(CONV) * 4 + 20);
    read_result("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
